// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit that writes its {hi, lo} result to the hi/lo register.
// Define MDU_DIV_EN to build the DIV state and the restoring divider. Without it, divide requests are ignored.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk_cpu,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                busy,
    output logic                hilo_wr_en,
    output logic [2*XLEN-1:0]   hilo_wr_data,
    output logic                div_by_zero
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MDU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [XLEN-1:0]    mag_a;
    logic [2*XLEN-1:0]  prod;
    logic               neg_res;

    logic               op_signed;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [XLEN-1:0]    mag_a_in;
    logic [XLEN-1:0]    mag_b_in;
    logic               last_iter;

    // MULT and DIV (op[0] = 0) work on magnitudes and fix the sign at the end
    always_comb begin
        op_signed = ~op[0];
        a_neg_in  = op_signed & a[XLEN-1];
        b_neg_in  = op_signed & b[XLEN-1];
        mag_a_in  = a_neg_in ? -a : a;
        mag_b_in  = b_neg_in ? -b : b;
        last_iter = (count == CW'(XLEN - 1));
    end

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;
    logic [2*XLEN-1:0]  mul_final;

    // Shift-add step: the multiplier sits in the low half and drains out as the product fills in
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mag_a};
        mul_next  = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
        mul_final = neg_res ? -mul_next : mul_next;
    end

`ifdef MDU_DIV_EN
    logic [XLEN-1:0]    a_raw;
    logic [XLEN-1:0]    mag_b;
    logic [XLEN-1:0]    rem;
    logic [XLEN-1:0]    quo;
    logic               neg_rem;
    logic               b_zero;
    logic               dz_q;

    logic [XLEN:0]      div_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff;
    logic [XLEN-1:0]    rem_next;
    logic [XLEN-1:0]    quo_next;
    logic [2*XLEN-1:0]  div_final;

    // Restoring step: the dividend shifts out of quo into rem while quotient bits shift in
    always_comb begin
        div_shift = {rem, quo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift[XLEN-1:0] - mag_b;
        rem_next  = div_ge ? div_diff : div_shift[XLEN-1:0];
        quo_next  = {quo[XLEN-2:0], div_ge};
        if (b_zero)
            div_final = {a_raw, {XLEN{1'b1}}};
        else
            div_final = {(neg_rem ? -rem_next : rem_next), (neg_res ? -quo_next : quo_next)};
    end

    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // Results are published only on the final iteration, so an abort never exposes a partial value
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            busy         <= 1'b0;
            hilo_wr_en   <= 1'b0;
            hilo_wr_data <= '0;
            mag_a        <= '0;
            prod         <= '0;
            neg_res      <= 1'b0;
`ifdef MDU_DIV_EN
            a_raw        <= '0;
            mag_b        <= '0;
            rem          <= '0;
            quo          <= '0;
            neg_rem      <= 1'b0;
            b_zero       <= 1'b0;
            dz_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    hilo_wr_en <= 1'b0;
                    count      <= '0;
                    if (start && !op[1]) begin
                        state   <= MUL;
                        busy    <= 1'b1;
                        mag_a   <= mag_a_in;
                        prod    <= {{XLEN{1'b0}}, mag_b_in};
                        neg_res <= a_neg_in ^ b_neg_in;
                    end
`ifdef MDU_DIV_EN
                    else if (start) begin
                        state   <= DIV;
                        busy    <= 1'b1;
                        a_raw   <= a;
                        mag_b   <= mag_b_in;
                        rem     <= '0;
                        quo     <= mag_a_in;
                        neg_res <= a_neg_in ^ b_neg_in;
                        neg_rem <= a_neg_in;
                        b_zero  <= (b == '0);
                    end
`endif
                end
                MUL: begin
                    prod  <= mul_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        state        <= DONE;
                        hilo_wr_en   <= 1'b1;
                        hilo_wr_data <= mul_final;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        state        <= DONE;
                        hilo_wr_en   <= 1'b1;
                        hilo_wr_data <= div_final;
                        dz_q         <= b_zero;
                    end
                end
`endif
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    hilo_wr_en <= 1'b0;
                    count      <= '0;
`ifdef MDU_DIV_EN
                    dz_q       <= 1'b0;
`endif
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    hilo_wr_en <= 1'b0;
                    count      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results are queued at start and checked on each hilo_wr_en strobe.
// Divide scenarios follow MDU_DIV_EN so the bench matches either build.
module tb_mul_div_unit;

    localparam int XLEN = 32;

    logic              clk_cpu = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              busy;
    logic              hilo_wr_en;
    logic [2*XLEN-1:0] hilo_wr_data;
    logic              div_by_zero;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .hilo_wr_en   (hilo_wr_en),
        .hilo_wr_data (hilo_wr_data),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Reference model built on native 64-bit arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx;
        longint sy;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        e.dz = 1'b0;
        case (o)
            2'b00: e.data = 64'(sx * sy);
            2'b01: e.data = 64'(ux * uy);
            2'b10: begin
                if (y == 32'b0) begin
                    e.data = {x, 32'hFFFFFFFF};
                    e.dz   = 1'b1;
                end else begin
                    e.data = {32'(sx % sy), 32'(sx / sy)};
                end
            end
            default: begin
                if (y == 32'b0) begin
                    e.data = {x, 32'hFFFFFFFF};
                    e.dz   = 1'b1;
                end else begin
                    e.data = {32'(ux % uy), 32'(ux / uy)};
                end
            end
        endcase
        return e;
    endfunction

    // Every strobe must match the oldest queued expectation
    always @(negedge clk_cpu) begin
        if (hilo_wr_en === 1'b1) begin
            exp_t e;
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_strobe: got data=%h, required no strobe", hilo_wr_data);
            end else begin
                e = sb_q.pop_front();
                if (hilo_wr_data !== e.data) begin
                    n_mismatched++;
                    $display("[TB] FAIL strobe_data: got %h, required %h", hilo_wr_data, e.data);
                end
                n_compared++;
                if (div_by_zero !== e.dz) begin
                    n_mismatched++;
                    $display("[TB] FAIL strobe_dz: got %b, required %b", div_by_zero, e.dz);
                end
            end
        end
    end

    task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk_cpu);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_cpu);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #1;
        n_compared += 4;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        if (hilo_wr_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wr_en: got %b, required 0", hilo_wr_en); end
        if (hilo_wr_data !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h, required 0", hilo_wr_data); end
        if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_dz: got %b, required 0", div_by_zero); end
        repeat (2) @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    task automatic test_multu_max();
        sb_q.push_back('{64'hFFFFFFFE_00000001, 1'b0});
        drive_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int j = 0; j <= 34; j++) begin
            if (j > 0) @(negedge clk_cpu);
            n_compared += 2;
            if (busy !== (j <= 32)) begin
                n_mismatched++;
                $display("[TB] FAIL multu_busy[%0d]: got %b, required %b", j, busy, (j <= 32));
            end
            if (hilo_wr_en !== (j == 32)) begin
                n_mismatched++;
                $display("[TB] FAIL multu_wr_en[%0d]: got %b, required %b", j, hilo_wr_en, (j == 32));
            end
        end
    endtask

    task automatic test_mult_signed();
        int busy_cycles = 0;
        sb_q.push_back('{64'hFFFFFFFF_FFFFFFFA, 1'b0});
        drive_start(2'b00, 32'hFFFFFFFE, 32'h00000003);
        for (int j = 0; j < 40; j++) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk_cpu);
        end
        n_compared++;
        if (busy_cycles != 33) begin
            n_mismatched++;
            $display("[TB] FAIL mult_busy_cycles: got %0d, required 33", busy_cycles);
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div_signed();
        bit to;
        sb_q.push_back('{64'hFFFFFFFF_FFFFFFFD, 1'b0});
        drive_start(2'b10, 32'hFFFFFFF9, 32'h00000002);
        wait_idle(to);
        n_compared++;
        if (to) begin n_mismatched++; $display("[TB] FAIL div_timeout: got busy stuck, required idle"); end
        sb_q.push_back('{64'h00000000_80000000, 1'b0});
        drive_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(to);
        n_compared++;
        if (to) begin n_mismatched++; $display("[TB] FAIL div_ovf_timeout: got busy stuck, required idle"); end
    endtask

    task automatic test_divu_zero();
        sb_q.push_back('{64'h00000064_FFFFFFFF, 1'b1});
        drive_start(2'b11, 32'h00000064, 32'h00000000);
        for (int j = 0; j <= 34; j++) begin
            if (j > 0) @(negedge clk_cpu);
            n_compared++;
            if (div_by_zero !== (j == 32)) begin
                n_mismatched++;
                $display("[TB] FAIL divu_zero_dz[%0d]: got %b, required %b", j, div_by_zero, (j == 32));
            end
        end
    endtask
`else
    task automatic test_div_ignored();
        for (int k = 0; k < 2; k++) begin
            drive_start(k == 0 ? 2'b10 : 2'b11, 32'h00000064, 32'h00000007);
            for (int j = 0; j < 5; j++) begin
                n_compared += 3;
                if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL div_ign_busy[%0d]: got %b, required 0", j, busy); end
                if (hilo_wr_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL div_ign_wr_en[%0d]: got %b, required 0", j, hilo_wr_en); end
                if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL div_ign_dz[%0d]: got %b, required 0", j, div_by_zero); end
                @(negedge clk_cpu);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit to;
        drive_start(2'b01, 32'h12345678, 32'h00000009);
        repeat (10) @(negedge clk_cpu);
        #1 reset = 1'b1;
        #1;
        n_compared += 4;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_busy: got %b, required 0", busy); end
        if (hilo_wr_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_wr_en: got %b, required 0", hilo_wr_en); end
        if (hilo_wr_data !== 64'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_data: got %h, required 0", hilo_wr_data); end
        if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_dz: got %b, required 0", div_by_zero); end
        @(negedge clk_cpu);
        reset = 1'b0;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        sb_q.push_back('{64'h00000000_0000000F, 1'b0});
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        start = 1'b0;
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_accept: got busy=%b, required 1", busy); end
        wait_idle(to);
        n_compared++;
        if (to) begin n_mismatched++; $display("[TB] FAIL post_reset_timeout: got busy stuck, required idle"); end
    endtask

    task automatic test_back_to_back();
        bit to;
        sb_q.push_back('{64'h00000000_00000006, 1'b0});
        drive_start(2'b01, 32'd2, 32'd3);
        repeat (4) @(negedge clk_cpu);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd7;
        b     = 32'd7;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        start = 1'b0;
        wait_idle(to);
        n_compared++;
        if (to) begin n_mismatched++; $display("[TB] FAIL b2b_timeout: got busy stuck, required idle"); end
        repeat (3) @(negedge clk_cpu);
        n_compared += 2;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_busy_after: got %b, required 0", busy); end
        if (hilo_wr_data !== 64'h6) begin n_mismatched++; $display("[TB] FAIL b2b_hold_data: got %h, required 6", hilo_wr_data); end
    endtask

    task automatic test_random();
        bit to;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 10; i++) begin
`ifdef MDU_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 4 == 1) y = -y;
            sb_q.push_back(model(o, x, y));
            drive_start(o, x, y);
            wait_idle(to);
            n_compared++;
            if (to) begin n_mismatched++; $display("[TB] FAIL random_timeout[%0d]: got busy stuck, required idle", i); end
        end
    endtask

    initial begin
        $display("[TB] starting mul_div_unit bench");
        test_reset();
        test_multu_max();
        test_mult_signed();
`ifdef MDU_DIV_EN
        test_div_signed();
        test_divu_zero();
`else
        test_div_ignored();
`endif
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk_cpu);
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL provide parameter: XLEN, 32, operand width; result width is 2*XLEN.
REQ-002 SHALL have port: clk_cpu  input  1  CPU clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  XLEN  multiplicand / dividend (rs).
REQ-007 SHALL have port: b  input  XLEN  multiplier / divisor (rt).
REQ-008 SHALL have port: busy  output  1  high while an operation is in flight, including the DONE cycle.
REQ-009 SHALL have port: hilo_wr_en  output  1  one-cycle result-write strobe to the hi/lo register.
REQ-010 SHALL have port: hilo_wr_data  output  2*XLEN  result {hi, lo}.
REQ-011 SHALL have port: div_by_zero  output  1  high only in the DONE cycle of a divide with b == 0.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-013 SHALL, in IDLE with start=1 at edge E0, latch a, b and op, and enter MUL (op[1]=0) or DIV (op[1]=1) with the iteration counter at 0.
REQ-014 SHALL, in MUL/DIV, perform one radix-2 iteration per cycle on unsigned magnitudes (shift-add multiply, restoring divide), entering DONE after edge E0+XLEN.
REQ-015 SHALL, in DONE, assert hilo_wr_en with hilo_wr_data valid for exactly one cycle, then return to IDLE at edge E0+XLEN+1.
REQ-016 SHALL drive busy=1 from edge E0 until edge E0+XLEN+1, and 0 in IDLE.
REQ-017 SHALL ignore start whenever busy=1; latched operands are not disturbed.
REQ-018 SHALL, for MULT, take magnitudes of both operands and two's-complement negate the 2*XLEN product when the operand signs differ; MULTU uses the raw operands.
REQ-019 SHALL, for divide, place the quotient in lo and the remainder in hi.
REQ-020 SHALL, for DIV, truncate the quotient toward zero, with the remainder taking the sign of the dividend.
REQ-021 SHALL, for DIV with a = -2^(XLEN-1) and b = -1, produce lo = 0x80000000 and hi = 0 with no flag.
REQ-022 SHALL, for a divide with b == 0, produce hi = a (raw) and lo = all ones, with div_by_zero=1 in DONE; latency is unchanged.
REQ-023 SHALL hold hilo_wr_data at the last result until the next DONE.

Reset
REQ-024 SHALL, on reset assertion, immediately force IDLE, busy=0, hilo_wr_en=0, div_by_zero=0, hilo_wr_data=0 and counter=0.
REQ-025 SHALL, on reset assertion mid-operation, abort with no hilo_wr_en pulse and no partial result visible.
REQ-026 SHALL accept start at the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro MDU_DIV_EN defined, include the DIV state and divider datapath, implementing REQ-019 to REQ-022.
REQ-028 SHALL, with MDU_DIV_EN undefined, omit the divider datapath and DIV state; start with op[1]=1 is ignored (busy stays 0, no hilo_wr_en, div_by_zero tied to 0).

Verification
REQ-029 SHALL verify MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 -> hilo_wr_en high only in the cycle after E0+32, with hilo_wr_data=0xFFFFFFFE_00000001.
REQ-030 SHALL verify MULT: a=0xFFFFFFFE, b=0x00000003 -> hilo_wr_data=0xFFFFFFFF_FFFFFFFA, busy high for 33 cycles.
REQ-031 SHALL verify DIV (MDU_DIV_EN defined): a=0xFFFFFFF9, b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-032 SHALL verify DIVU divide-by-zero: a=0x00000064, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 for one cycle.
REQ-033 SHALL verify reset mid-MULT: reset asserted 10 cycles after start -> busy=0, hilo_wr_data=0, no strobe; a new MULTU 3*5 after release -> 0x00000000_0000000F.
REQ-034 SHALL verify start ignored while busy: MULTU 2*3 then start MULTU 7*7 at E0+5 -> single strobe with 0x6; with MDU_DIV_EN undefined, DIV start -> busy stays 0.
